// File: rtl/lap_recorder.sv
// Lap recorder for the 1 Hz stopwatch.
//
// Captures the live hh:mm:ss on each lap press. Each capture stores the lap
// total and the split, which is the time since the previous capture. Entries
// go into a circular buffer of DEPTH = 2**AW entries. A view button steps
// through the stored laps, oldest first. The display bus shows live time in
// LIVE and the selected stored lap in VIEW.
//
// Optional feature (macro LAP_OVERWRITE_EN):
//   defined   - a lap on a full buffer overwrites the oldest entry
//   undefined - a lap on a full buffer is ignored
//
// Ports:
//   clk_1Hz       1 Hz clock
//   resetn        asynchronous active-low reset
//   clear_in      synchronous clear: empties buffer, returns to LIVE
//   lap_in        one-cycle lap pulse
//   view_in       one-cycle view/advance pulse
//   split_sel_in  0 = show lap total, 1 = show split (VIEW only)
//   hour_in/min_in/sec_in     live time from the stopwatch core
//   hour_out/min_out/sec_out  displayed time
//   lap_idx_out   index of displayed lap (0 = oldest), 0 in LIVE
//   count_out     number of stored laps, 0..DEPTH
//   full_out      buffer full
//   viewing_out   1 in VIEW
module lap_recorder #(
  parameter int unsigned AW = 2
) (
  input  logic          clk_1Hz,
  input  logic          resetn,
  input  logic          clear_in,
  input  logic          lap_in,
  input  logic          view_in,
  input  logic          split_sel_in,
  input  logic [4:0]    hour_in,
  input  logic [5:0]    min_in,
  input  logic [5:0]    sec_in,
  output logic [4:0]    hour_out,
  output logic [5:0]    min_out,
  output logic [5:0]    sec_out,
  output logic [AW-1:0] lap_idx_out,
  output logic [AW:0]   count_out,
  output logic          full_out,
  output logic          viewing_out
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [0:0] {StLive, StView} state_e;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   old_ptr_q, old_ptr_d;
  logic [AW-1:0]   view_idx_q, view_idx_d;
  hms_t            last_q, last_d;
  logic            we;

  hms_t            total_mem [DEPTH];
  hms_t            split_mem [DEPTH];

  hms_t            live;
  hms_t            split;
  hms_t            rd_total, rd_split;
  logic [AW-1:0]   rd_addr;
  logic [AW:0]     view_next;

  // Split arithmetic intermediates
  logic            sec_borrow, min_borrow;
  logic [6:0]      sec_wide, min_wide, min_sub;

  assign live = '{h: hour_in, m: min_in, s: sec_in};

  // Split = live - last with mixed-radix borrow. If the stopwatch went
  // backwards (reset without clearing us), treat the capture as a fresh start.
  always_comb begin
    sec_borrow = sec_in < last_q.s;
    sec_wide   = sec_borrow ? ({1'b0, sec_in} + 7'd60 - {1'b0, last_q.s})
                            : ({1'b0, sec_in} - {1'b0, last_q.s});
    min_sub    = {1'b0, last_q.m} + {6'd0, sec_borrow};
    min_borrow = {1'b0, min_in} < min_sub;
    min_wide   = min_borrow ? ({1'b0, min_in} + 7'd60 - min_sub)
                            : ({1'b0, min_in} - min_sub);
    if (live < last_q) begin
      split = live;
    end else begin
      split.s = sec_wide[5:0];
      split.m = min_wide[5:0];
      split.h = hour_in - last_q.h - {4'd0, min_borrow};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    old_ptr_d  = old_ptr_q;
    view_idx_d = view_idx_q;
    last_d     = last_q;
    we         = 1'b0;
    view_next  = {1'b0, view_idx_q} + (AW + 1)'(1);

    if (clear_in) begin
      state_d    = StLive;
      count_d    = '0;
      wr_ptr_d   = '0;
      old_ptr_d  = '0;
      view_idx_d = '0;
      last_d     = '0;
    end else if (lap_in) begin
      if (!full_q) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + (AW + 1)'(1);
        last_d   = live;
      end else begin
`ifdef LAP_OVERWRITE_EN
        // Overwrite oldest; view index is held so the display slides newer.
        we        = 1'b1;
        wr_ptr_d  = wr_ptr_q + AW'(1);
        old_ptr_d = old_ptr_q + AW'(1);
        last_d    = live;
`else
        // Ignored entirely; last_q keeps the last stored lap.
        we        = 1'b0;
`endif
      end
    end else if (view_in) begin
      unique case (state_q)
        StLive: begin
          if (count_q != '0) begin
            state_d    = StView;
            view_idx_d = '0;
          end
        end
        StView: begin
          if (view_next == count_q) begin
            state_d    = StLive;
            view_idx_d = '0;
          end else begin
            view_idx_d = view_idx_q + AW'(1);
          end
        end
        default: state_d = StLive;
      endcase
    end

    full_d = (count_d == (AW + 1)'(DEPTH));
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StLive;
      count_q    <= '0;
      full_q     <= 1'b0;
      wr_ptr_q   <= '0;
      old_ptr_q  <= '0;
      view_idx_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      old_ptr_q  <= old_ptr_d;
      view_idx_q <= view_idx_d;
      last_q     <= last_d;
    end
  end

  // Buffer contents need no reset; count_q gates what is visible.
  always_ff @(posedge clk_1Hz) begin
    if (we) begin
      total_mem[wr_ptr_q] <= live;
      split_mem[wr_ptr_q] <= split;
    end
  end

  // Address arithmetic wraps naturally modulo DEPTH.
  assign rd_addr  = old_ptr_q + view_idx_q;
  assign rd_total = total_mem[rd_addr];
  assign rd_split = split_mem[rd_addr];

  always_comb begin
    hour_out = hour_in;
    min_out  = min_in;
    sec_out  = sec_in;
    if (state_q == StView) begin
      if (split_sel_in) begin
        hour_out = rd_split.h;
        min_out  = rd_split.m;
        sec_out  = rd_split.s;
      end else begin
        hour_out = rd_total.h;
        min_out  = rd_total.m;
        sec_out  = rd_total.s;
      end
    end
  end

  assign lap_idx_out = view_idx_q;
  assign count_out   = count_q;
  assign full_out    = full_q;
  assign viewing_out = (state_q == StView);

endmodule
